sig_counter_bank: RTL and testbench

Multi-channel event counter bank. It counts edges on CHANNELS independent single-bit signals, with a per-channel edge mode, configurable counter width, and a choice of wrap or saturate on overflow. It has a global clear, an atomic snapshot into shadow registers, and a registered indexed readout. It sits alongside the MPU control path as a debug and performance-monitor block, counting handshake and status strobes.

---
 rtl/sig_counter_bank.sv | 105 ++++++++++
 tb/tb_sig_counter_bank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_counter_bank.sv
// Multi-channel edge counter bank with per-channel edge mode, wrap/saturate overflow,
// global clear, atomic snapshot into shadow registers and a registered indexed readout.
module sig_counter_bank #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned SEL_WIDTH = 2,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   sig,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  snap,
  input  logic [SEL_WIDTH-1:0]  rd_sel,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  rd_ovf,
  output logic                  any_ovf
);

  logic [CHANNELS-1:0]  sig_last_q;
  logic [CHANNELS-1:0]  hit;
  logic [CHANNELS-1:0]  ovf_q, ovf_d;
  logic [CHANNELS-1:0]  shadow_ovf_q;
  logic [CNT_WIDTH-1:0] cnt_q        [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d        [CHANNELS];
  logic [CNT_WIDTH-1:0] shadow_cnt_q [CHANNELS];
  logic [CNT_WIDTH-1:0] rd_data_d;
  logic                 rd_ovf_d;

  always_comb begin
    hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      unique case (mode[2*i +: 2])
        2'b01:   hit[i] = sig[i] & ~sig_last_q[i];
        2'b10:   hit[i] = ~sig[i] & sig_last_q[i];
        2'b11:   hit[i] = sig[i] ^ sig_last_q[i];
        default: hit[i] = 1'b0;
      endcase
    end
  end

  // clear outranks a simultaneous hit, so that edge is dropped
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (enable && hit[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = SATURATE ? cnt_q[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Out-of-range selects match no channel and read back as zero
  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_sel == SEL_WIDTH'(i)) begin
        rd_data_d = shadow_cnt_q[i];
        rd_ovf_d  = shadow_ovf_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    sig_last_q <= sig;
    if (rst) begin
      ovf_q        <= '0;
      shadow_ovf_q <= '0;
      rd_data      <= '0;
      rd_ovf       <= 1'b0;
      any_ovf      <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]        <= '0;
        shadow_cnt_q[i] <= '0;
      end
    end else begin
      ovf_q   <= ovf_d;
      any_ovf <= |ovf_q;
      rd_data <= rd_data_d;
      rd_ovf  <= rd_ovf_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      // Snapshot takes pre-update values: same-cycle hits and clear are not seen
      if (snap) begin
        shadow_ovf_q <= ovf_q;
        for (int i = 0; i < CHANNELS; i++) begin
          shadow_cnt_q[i] <= cnt_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_sig_counter_bank.sv
// Directed bench for sig_counter_bank: wrap, saturate and 3-channel instances share stimulus.
module tb_sig_counter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sig;
  logic [7:0] mode;
  logic       enable, clear, snap;
  logic [1:0] rd_sel;
  logic [7:0] rd_data_w, rd_data_s, rd_data_3;
  logic       rd_ovf_w, rd_ovf_s, rd_ovf_3;
  logic       any_ovf_w, any_ovf_s, any_ovf_3;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sig_counter_bank #(.CHANNELS(4), .CNT_WIDTH(8), .SEL_WIDTH(2), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .sig(sig), .mode(mode), .enable(enable), .clear(clear), .snap(snap),
    .rd_sel(rd_sel), .rd_data(rd_data_w), .rd_ovf(rd_ovf_w), .any_ovf(any_ovf_w)
  );

  sig_counter_bank #(.CHANNELS(4), .CNT_WIDTH(8), .SEL_WIDTH(2), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .sig(sig), .mode(mode), .enable(enable), .clear(clear), .snap(snap),
    .rd_sel(rd_sel), .rd_data(rd_data_s), .rd_ovf(rd_ovf_s), .any_ovf(any_ovf_s)
  );

  sig_counter_bank #(.CHANNELS(3), .CNT_WIDTH(8), .SEL_WIDTH(2), .SATURATE(1'b0)) dut_ch3 (
    .clk(clk), .rst(rst), .sig(sig[2:0]), .mode(mode[5:0]), .enable(enable), .clear(clear),
    .snap(snap), .rd_sel(rd_sel), .rd_data(rd_data_3), .rd_ovf(rd_ovf_3), .any_ovf(any_ovf_3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; snap = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // n full pulses (rise then fall) on the channels set in chmask
  task automatic pulses(input logic [3:0] chmask, input int n);
    for (int k = 0; k < n; k++) begin
      sig = sig | chmask;
      tick();
      sig = sig & ~chmask;
      tick();
    end
  endtask

  task automatic do_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic read_sel(input logic [1:0] sel);
    rd_sel = sel;
    tick();
  endtask

  task automatic test_reset();
    sig = 4'h0; mode = 8'h00; enable = 1'b0; rd_sel = 2'd0;
    do_reset();
    tests_run++;
    if (rd_data_w !== 8'd0) begin
      tests_failed++; $display("FAIL reset_rd_data: got %0d want 0", rd_data_w);
    end
    tests_run++;
    if (rd_ovf_w !== 1'b0) begin
      tests_failed++; $display("FAIL reset_rd_ovf: got %0b want 0", rd_ovf_w);
    end
    tests_run++;
    if (any_ovf_w !== 1'b0 || any_ovf_s !== 1'b0) begin
      tests_failed++; $display("FAIL reset_any_ovf: got %0b/%0b want 0/0", any_ovf_w, any_ovf_s);
    end
  endtask

  task automatic test_rising();
    logic [7:0] exp;
    do_reset();
    mode = 8'b00_00_00_01; enable = 1'b1;
    pulses(4'b0001, 5);
    do_snap();
    for (int c = 0; c < 4; c++) begin
      read_sel(2'(c));
      exp = (c == 0) ? 8'd5 : 8'd0;
      tests_run++;
      if (rd_data_w !== exp || rd_ovf_w !== 1'b0) begin
        tests_failed++;
        $display("FAIL rising_ch%0d: got %0d ovf %0b want %0d ovf 0", c, rd_data_w, rd_ovf_w, exp);
      end
    end
  endtask

  task automatic test_modes();
    do_reset();
    mode = 8'b00_10_11_00; enable = 1'b1;
    pulses(4'b0110, 3);
    do_snap();
    read_sel(2'd1);
    tests_run++;
    if (rd_data_w !== 8'd6) begin
      tests_failed++; $display("FAIL both_edges_ch1: got %0d want 6", rd_data_w);
    end
    read_sel(2'd2);
    tests_run++;
    if (rd_data_w !== 8'd3) begin
      tests_failed++; $display("FAIL falling_ch2: got %0d want 3", rd_data_w);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    mode = 8'b00_00_00_01; enable = 1'b1;
    pulses(4'b0001, 255);
    tick();
    tests_run++;
    if (any_ovf_w !== 1'b0 || any_ovf_s !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_early: got any_ovf %0b/%0b want 0/0 at count 255", any_ovf_w, any_ovf_s);
    end
    pulses(4'b0001, 2);
    do_snap();
    read_sel(2'd0);
    tests_run++;
    if (rd_data_w !== 8'd1 || rd_ovf_w !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_257: got %0d ovf %0b want 1 ovf 1", rd_data_w, rd_ovf_w);
    end
    tests_run++;
    if (rd_data_s !== 8'd255 || rd_ovf_s !== 1'b1) begin
      tests_failed++;
      $display("FAIL saturate_257: got %0d ovf %0b want 255 ovf 1", rd_data_s, rd_ovf_s);
    end
    tests_run++;
    if (any_ovf_w !== 1'b1 || any_ovf_s !== 1'b1) begin
      tests_failed++; $display("FAIL any_ovf: got %0b/%0b want 1/1", any_ovf_w, any_ovf_s);
    end
  endtask

  task automatic test_reset_held_and_clear();
    mode = 8'b00_00_00_01; enable = 1'b1; rd_sel = 2'd0;
    sig = 4'b0001;
    do_reset();
    tests_run++;
    if (any_ovf_w !== 1'b0 || rd_ovf_w !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_clears_ovf: got any %0b rd %0b want 0/0", any_ovf_w, rd_ovf_w);
    end
    for (int k = 0; k < 10; k++) tick();
    sig = 4'b0000;
    tick();
    do_snap();
    read_sel(2'd0);
    tests_run++;
    if (rd_data_w !== 8'd0) begin
      tests_failed++; $display("FAIL held_high_reset: got %0d want 0", rd_data_w);
    end
    sig = 4'b0001; clear = 1'b1;
    tick();
    clear = 1'b0; sig = 4'b0000;
    tick();
    do_snap();
    read_sel(2'd0);
    tests_run++;
    if (rd_data_w !== 8'd0) begin
      tests_failed++; $display("FAIL clear_beats_edge: got %0d want 0", rd_data_w);
    end
  endtask

  task automatic test_snap_clear();
    do_reset();
    mode = 8'b01_00_00_00; enable = 1'b1; rd_sel = 2'd3;
    pulses(4'b1000, 7);
    snap = 1'b1; clear = 1'b1;
    tick();
    snap = 1'b0; clear = 1'b0;
    tests_run++;
    if (rd_data_w !== 8'd0) begin
      tests_failed++; $display("FAIL snap_latency: got %0d want 0 one cycle after snap", rd_data_w);
    end
    tick();
    tests_run++;
    if (rd_data_w !== 8'd7) begin
      tests_failed++; $display("FAIL snap_with_clear: got %0d want 7", rd_data_w);
    end
    pulses(4'b1000, 1);
    do_snap();
    tick();
    tests_run++;
    if (rd_data_w !== 8'd1) begin
      tests_failed++; $display("FAIL post_clear_count: got %0d want 1", rd_data_w);
    end
  endtask

  task automatic test_enable_and_sel();
    do_reset();
    mode = 8'hFF; enable = 1'b0;
    pulses(4'b1111, 3);
    enable = 1'b1;
    tick();
    do_snap();
    for (int c = 0; c < 4; c++) begin
      read_sel(2'(c));
      tests_run++;
      if (rd_data_w !== 8'd0) begin
        tests_failed++; $display("FAIL enable_off_ch%0d: got %0d want 0", c, rd_data_w);
      end
    end
    pulses(4'b1111, 1);
    do_snap();
    read_sel(2'd3);
    tests_run++;
    if (rd_data_w !== 8'd2) begin
      tests_failed++; $display("FAIL enabled_ch3: got %0d want 2", rd_data_w);
    end
    tests_run++;
    if (rd_data_3 !== 8'd0 || rd_ovf_3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL sel_out_of_range: got %0d ovf %0b want 0 ovf 0", rd_data_3, rd_ovf_3);
    end
    read_sel(2'd2);
    tests_run++;
    if (rd_data_3 !== 8'd2) begin
      tests_failed++; $display("FAIL ch3_inst_ch2: got %0d want 2", rd_data_3);
    end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_modes();
    test_overflow();
    test_reset_held_and_clear();
    test_snap_clear();
    test_enable_and_sel();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
